// File: rtl/md_unit_if.sv
// ============================================================================
// Module  : md_unit_if
// Brief   : E-stage multiply/divide issue and HI/LO read bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_sel;
  logic [31:0] mdOut_E;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_start, md_op, rs_E, rt_E, md_sel,
    input  mdOut_E, busy, hi, lo
  );

  modport slave (
    input  md_start, md_op, rs_E, rt_E, md_sel,
    output mdOut_E, busy, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module  : md_unit
// Brief   : Multi-cycle mult/div unit with architectural HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  md_unit_if.slave   bus
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0] w_rs_sx;
  logic [63:0] w_rt_sx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // Low 64 bits of the sign-extended 64x64 product are the exact signed 32x32 product.
  assign w_rs_sx  = {{32{bus.rs_E[31]}}, bus.rs_E};
  assign w_rt_sx  = {{32{bus.rt_E[31]}}, bus.rt_E};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {32'd0, bus.rs_E} * {32'd0, bus.rt_E};

  logic        w_signed_div;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic        w_div0;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_den_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_signed_div = (bus.md_op == c_OP_DIV);
  assign w_rs_neg     = w_signed_div & bus.rs_E[31];
  assign w_rt_neg     = w_signed_div & bus.rt_E[31];
  assign w_div0       = (bus.rt_E == 32'd0);
  assign w_num        = w_rs_neg ? (32'd0 - bus.rs_E) : bus.rs_E;
  assign w_den        = w_rt_neg ? (32'd0 - bus.rt_E) : bus.rt_E;
  assign w_den_safe   = w_div0 ? 32'd1 : w_den;
  assign w_q_mag      = w_num / w_den_safe;
  assign w_r_mag      = w_num % w_den_safe;
  assign w_q_fin      = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_fin      = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.md_start) begin
            case (bus.md_op)
              c_OP_MULT: begin
                r_pend  <= w_prod_s;
                r_cnt   <= c_MULT_CNT;
                r_state <= c_RUN;
              end
              c_OP_MULTU: begin
                r_pend  <= w_prod_u;
                r_cnt   <= c_MULT_CNT;
                r_state <= c_RUN;
              end
              c_OP_DIV, c_OP_DIVU: begin
                // Zero divisor still burns the full busy period but commits HI/LO unchanged.
                r_pend  <= w_div0 ? {r_hi, r_lo} : {w_r_fin, w_q_fin};
                r_cnt   <= c_DIV_CNT;
                r_state <= c_RUN;
              end
              c_OP_MTHI: r_hi <= bus.rs_E;
              c_OP_MTLO: r_lo <= bus.rs_E;
              default: ;
            endcase
          end
        end
        c_RUN: begin
          if (r_cnt == c_CNT_ONE) begin
            r_hi    <= r_pend[63:32];
            r_lo    <= r_pend[31:0];
            r_cnt   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == c_RUN);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.mdOut_E = bus.md_sel ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module  : tb_md_unit
// Brief   : Directed and randomized checks of md_unit against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Architectural result of one op on (HI,LO), from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt, input logic [31:0] ch,
                                         input logic [31:0] cl);
    longint a, b, q, r;
    logic [63:0] ua, ub;
    a = $signed(rs);
    b = $signed(rt);
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      3'd1: begin q = a * b; return q; end
      3'd2: return ua * ub;
      3'd3: begin
        if (rt == 32'd0) return {ch, cl};
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (rt == 32'd0) return {ch, cl};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd5: return {rs, cl};
      3'd6: return {ch, rs};
      default: return {ch, cl};
    endcase
  endfunction

  function automatic int op_cycles(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  // One-cycle issue pulse; operands are scrambled afterwards.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.md_start = 1'b1;
    bus.md_op    = op;
    bus.rs_E     = rs;
    bus.rt_E     = rt;
    @(posedge clk); #1;
    bus.md_start = 1'b0;
    bus.md_op    = 3'($urandom_range(0, 7));
    bus.rs_E     = $urandom;
    bus.rt_E     = $urandom;
  endtask

  task automatic test_reset();
    bus.md_sel = 1'b0;
    #12;
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL reset_state: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
    else n_pass++;
    n_total++; if (bus.mdOut_E !== 32'd0)
      $display("FAIL reset_mdout: got %h expected 00000000", bus.mdOut_E);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [2:0]  ops [2] = '{3'd2, 3'd1};
    logic [31:0] rss [2] = '{32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] rts [2] = '{32'h00000002, 32'h00000005};
    logic [31:0] ehs [2] = '{32'h00000001, 32'hFFFFFFFF};
    logic [31:0] els [2] = '{32'hFFFFFFFE, 32'hFFFFFFF1};
    for (int t = 0; t < 2; t++) begin
      drive_op(ops[t], rss[t], rts[t]);
      for (int c = 0; c < MC; c++) begin
        n_total++; if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL mult_busy t%0d c%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                   t, c, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        else n_pass++;
        @(posedge clk); #1;
      end
      {m_hi, m_lo} = ref_md(ops[t], rss[t], rts[t], m_hi, m_lo);
      n_total++; if (bus.busy !== 1'b0 || bus.hi !== ehs[t] || bus.lo !== els[t])
        $display("FAIL mult_result t%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 t, bus.busy, bus.hi, bus.lo, ehs[t], els[t]);
      else n_pass++;
      bus.md_sel = 1'b1; #1;
      n_total++; if (bus.mdOut_E !== m_hi)
        $display("FAIL mult_mdout_hi t%0d: got %h expected %h", t, bus.mdOut_E, m_hi);
      else n_pass++;
      bus.md_sel = 1'b0; #1;
      n_total++; if (bus.mdOut_E !== m_lo)
        $display("FAIL mult_mdout_lo t%0d: got %h expected %h", t, bus.mdOut_E, m_lo);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [3] = '{3'd3, 3'd4, 3'd3};
    logic [31:0] rss [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] rts [3] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF};
    logic [31:0] ehs [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    logic [31:0] els [3] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000};
    for (int t = 0; t < 3; t++) begin
      drive_op(ops[t], rss[t], rts[t]);
      for (int c = 0; c < DC; c++) begin
        n_total++; if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL div_busy t%0d c%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                   t, c, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        else n_pass++;
        @(posedge clk); #1;
      end
      {m_hi, m_lo} = ref_md(ops[t], rss[t], rts[t], m_hi, m_lo);
      n_total++; if (bus.busy !== 1'b0 || bus.hi !== ehs[t] || bus.lo !== els[t] || bus.lo !== m_lo)
        $display("FAIL div_result t%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                 t, bus.busy, bus.hi, bus.lo, ehs[t], els[t]);
      else n_pass++;
    end
  endtask

  task automatic test_mt_divzero();
    drive_op(3'd5, 32'h12345678, 32'd0);
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'h12345678)
      $display("FAIL mthi: busy=%b hi=%h expected busy=0 hi=12345678", bus.busy, bus.hi);
    else n_pass++;
    drive_op(3'd6, 32'h9ABCDEF0, 32'd0);
    n_total++; if (bus.busy !== 1'b0 || bus.lo !== 32'h9ABCDEF0 || bus.hi !== 32'h12345678)
      $display("FAIL mtlo: busy=%b hi=%h lo=%h expected busy=0 hi=12345678 lo=9abcdef0",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
    m_hi = 32'h12345678;
    m_lo = 32'h9ABCDEF0;
    drive_op(3'd4, 32'hCAFEF00D, 32'd0);
    for (int c = 0; c < DC; c++) begin
      n_total++; if (bus.busy !== 1'b1)
        $display("FAIL divzero_busy c%0d: got busy=%b expected 1", c, bus.busy);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'h12345678 || bus.lo !== 32'h9ABCDEF0)
      $display("FAIL divzero_result: busy=%b hi=%h lo=%h expected busy=0 hi=12345678 lo=9abcdef0",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] rs, rt;
    rs = $urandom;
    rt = $urandom;
    drive_op(3'd1, rs, rt);
    drive_op(3'd6, 32'h0000DEAD, 32'd0);
    drive_op(3'd5, 32'h0000BEEF, 32'd0);
    drive_op(3'd2, $urandom, $urandom);
    for (int c = 3; c < MC; c++) begin
      n_total++; if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
        $display("FAIL ignore_busy c%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                 c, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
      else n_pass++;
      @(posedge clk); #1;
    end
    {m_hi, m_lo} = ref_md(3'd1, rs, rt, m_hi, m_lo);
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
      $display("FAIL ignore_result: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
               bus.busy, bus.hi, bus.lo, m_hi, m_lo);
    else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.busy !== 1'b0)
      $display("FAIL ignore_no_restart: got busy=%b expected 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    drive_op(3'd3, 32'h7FFF1234, 32'h00000013);
    repeat (3) begin @(posedge clk); #1; end
    n_total++; if (bus.busy !== 1'b1)
      $display("FAIL midrun_pre: got busy=%b expected 1", bus.busy);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL midrun_async: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (DC) begin @(posedge clk); end
    #1;
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL midrun_discard: busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
    drive_op(3'd5, 32'd1, 32'd0);
    m_hi = 32'd1;
    n_total++; if (bus.busy !== 1'b0 || bus.hi !== 32'd1 || bus.lo !== 32'd0)
      $display("FAIL midrun_mthi: busy=%b hi=%h lo=%h expected busy=0 hi=1 lo=0",
               bus.busy, bus.hi, bus.lo);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int n;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: rt = 32'd0;
        1: rt = 32'hFFFFFFFF;
        2: rt = 32'($urandom_range(1, 9));
        default: rt = $urandom;
      endcase
      n = op_cycles(op);
      drive_op(op, rs, rt);
      for (int c = 0; c < n; c++) begin
        n_total++; if (bus.busy !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
          $display("FAIL rand_busy i%0d c%0d: busy=%b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                   i, c, bus.busy, bus.hi, bus.lo, m_hi, m_lo);
        else n_pass++;
        if ($urandom_range(0, 3) == 0) drive_op(3'($urandom_range(0, 7)), $urandom, $urandom);
        else begin @(posedge clk); #1; end
      end
      {m_hi, m_lo} = ref_md(op, rs, rt, m_hi, m_lo);
      bus.md_sel = 1'($urandom_range(0, 1));
      #1;
      n_total++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo ||
                     bus.mdOut_E !== (bus.md_sel ? m_hi : m_lo))
        $display("FAIL rand_result i%0d op%0d: busy=%b hi=%h lo=%h out=%h expected busy=0 hi=%h lo=%h",
                 i, op, bus.busy, bus.hi, bus.lo, bus.mdOut_E, m_hi, m_lo);
      else n_pass++;
    end
  endtask

  initial begin
    bus.md_start = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_E     = 32'd0;
    bus.rt_E     = 32'd0;
    bus.md_sel   = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
